mem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single unified memory port of the NPC core. It shares that port between instruction fetch (IFU, read-only) and load/store (LSU, read/write), and runs one transaction at a time through a request/response handshake. It sits between the IFU/LSU and the memory back-end (DPI-backed SRAM model or bus bridge). It also covers back-end stalls with a timeout that returns an error response.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_rr2.sv | 35 +++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    MID_IFU = 1'b0,
    MID_LSU = 1'b1
  } master_id_t;

endpackage : mem_arb_pkg

// File: rtl/arb_rr2.sv
// Two-way round-robin grant with its own last-grant history.
// gnt[0] = IFU, gnt[1] = LSU; on a tie the master that did not win last time wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  master_id_t last_grant;

  // Combinational grant: single requester wins, tie goes to the other master
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == MID_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was granted; reset to IFU so LSU wins the first tie
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_grant <= MID_IFU;
    end else if (accept) begin
      last_grant <= gnt[1] ? MID_LSU : MID_IFU;
    end
  end

endmodule : arb_rr2

// File: rtl/mem_arbiter.sv
// Shares the single unified memory port between IFU fetches and LSU accesses,
// one transaction at a time, with a timeout that forces an error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W  = ADDR_W_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned MASK_W  = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  // instruction fetch
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  // load/store
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,
  // memory back-end
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  // status
  output logic              busy,
  output logic              owner
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic              grant_c;
  logic              rsp_take_c;
  logic              timeout_c;
  logic              rsp_fire_c;
  logic [DATA_W-1:0] rsp_data_c;
  logic              rsp_err_c;

  // Requests are only visible to the arbiter while idle
  assign arb_req = (state == IDLE) ? {lsu_req_valid, ifu_req_valid} : 2'b00;
  assign grant_c = |gnt;

  arb_rr2 u_rr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (arb_req),
    .accept  (grant_c),
    .gnt     (gnt)
  );

  assign ifu_req_ready = gnt[0];
  assign lsu_req_ready = gnt[1];

  // Response payload: real back-end data, or zero data with err on timeout
  assign rsp_fire_c = rsp_take_c | timeout_c;
  assign rsp_data_c = rsp_take_c ? mem_rsp_data : '0;
  assign rsp_err_c  = timeout_c | (rsp_take_c & mem_rsp_err);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and transaction strobes; a real response beats the timeout
  always_comb begin
    state_nxt  = state;
    rsp_take_c = 1'b0;
    timeout_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_c) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (cnt == CNT_LAST) begin
          timeout_c = 1'b1;
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rsp_take_c = 1'b1;
          state_nxt  = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request; IFU fetches never write
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_c) begin
      owner <= gnt[1];
      if (gnt[1]) begin
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
      end else begin
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end
    end
  end

  // Registered status derived from the upcoming state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem_req_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mem_req_valid <= (state_nxt == ISSUE);
      busy          <= (state_nxt != IDLE);
    end
  end

  // Timeout counter: cleared at grant, counts every ISSUE/WAIT cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (grant_c) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Per-master response registers: one-cycle valid pulse, data/err held
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      if (rsp_fire_c) begin
        if (owner) begin
          lsu_rsp_valid <= 1'b1;
          lsu_rsp_data  <= rsp_data_c;
          lsu_rsp_err   <= rsp_err_c;
        end else begin
          ifu_rsp_valid <= 1'b1;
          ifu_rsp_data  <= rsp_data_c;
          ifu_rsp_err   <= rsp_err_c;
        end
      end
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the round-robin run,
// then hand-written sequences for stalls, timeout, reset and error responses.
module tb_mem_arbiter;

  localparam logic [31:0] IA  = 32'h8000_0000;
  localparam logic [31:0] LA  = 32'h8000_2000;
  localparam logic [31:0] BAD = 32'hBAD0_0BAD;
  localparam logic [31:0] D2  = 32'h1111_0002;
  localparam logic [31:0] D5  = 32'h2222_0005;
  localparam logic [31:0] D8  = 32'h3333_0008;
  localparam logic [31:0] D11 = 32'h4444_000B;

  logic        sys_clk;
  logic        sys_rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        busy, owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        iv, lv, mrdy, mrv;
    logic [31:0] mdata;
    logic        e_iry, e_lry, e_mrqv, e_busy, e_irv, e_lrv, e_own;
    logic [31:0] e_idata, e_ldata, e_maddr;
  } vec_t;

  vec_t vecs [13];

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .busy          (busy),
    .owner         (owner)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'h0;
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_err   = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // cycle table: both masters held high, back-end always ready/responding
    //              iv    lv    mrdy  mrv   mdata  iry   lry   mrqv  busy  irv   lrv   own   idata  ldata  maddr
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, BAD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, LA};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, D2,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, LA};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, D2,    LA};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, BAD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, D2,    IA};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, D5,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, D2,    IA};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, D5,    D2,    IA};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, BAD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, D5,    D2,    LA};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, D8,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, D5,    D2,    LA};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, D5,    D8,    LA};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, BAD,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, D5,    D8,    IA};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, D11,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, D5,    D8,    IA};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, D11,   D8,    IA};

    // ---------------- reset ----------------
    clear_inputs();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    #1;
    chk1 ("reset busy",          busy,          1'b0);
    chk1 ("reset owner",         owner,         1'b0);
    chk1 ("reset mem_req_valid", mem_req_valid, 1'b0);
    chk32("reset mem_addr",      mem_addr,      32'h0);
    chk1 ("reset ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    chk1 ("reset lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    chk32("reset ifu_rsp_data",  ifu_rsp_data,  32'h0);
    chk1 ("reset lsu_rsp_err",   lsu_rsp_err,   1'b0);

    // ---------------- round-robin table: L, I, L, I ----------------
    ifu_addr = IA;
    lsu_addr = LA;
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      ifu_req_valid = vecs[i].iv;
      lsu_req_valid = vecs[i].lv;
      mem_req_ready = vecs[i].mrdy;
      mem_rsp_valid = vecs[i].mrv;
      mem_rsp_data  = vecs[i].mdata;
      #1;
      chk1 ($sformatf("row%0d ifu_req_ready", i), ifu_req_ready, vecs[i].e_iry);
      chk1 ($sformatf("row%0d lsu_req_ready", i), lsu_req_ready, vecs[i].e_lry);
      chk1 ($sformatf("row%0d mem_req_valid", i), mem_req_valid, vecs[i].e_mrqv);
      chk1 ($sformatf("row%0d busy", i),          busy,          vecs[i].e_busy);
      chk1 ($sformatf("row%0d ifu_rsp_valid", i), ifu_rsp_valid, vecs[i].e_irv);
      chk1 ($sformatf("row%0d lsu_rsp_valid", i), lsu_rsp_valid, vecs[i].e_lrv);
      chk1 ($sformatf("row%0d owner", i),         owner,         vecs[i].e_own);
      chk32($sformatf("row%0d ifu_rsp_data", i),  ifu_rsp_data,  vecs[i].e_idata);
      chk32($sformatf("row%0d lsu_rsp_data", i),  lsu_rsp_data,  vecs[i].e_ldata);
      chk32($sformatf("row%0d mem_addr", i),      mem_addr,      vecs[i].e_maddr);
    end

    // ---------------- IFU alone, 3-cycle turnaround ----------------
    next_cycle();
    clear_inputs();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_req_ready = 1'b1;
    #1;
    chk1("ifu_alone ready", ifu_req_ready, 1'b1);
    chk1("ifu_alone lsu_ready", lsu_req_ready, 1'b0);
    next_cycle();
    ifu_req_valid = 1'b0;
    #1;
    chk1 ("ifu_alone t1 mem_req_valid", mem_req_valid, 1'b1);
    chk32("ifu_alone t1 mem_addr", mem_addr, 32'h8000_0000);
    chk1 ("ifu_alone t1 busy", busy, 1'b1);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0413;
    #1;
    chk1("ifu_alone t2 mem_req_valid", mem_req_valid, 1'b0);
    chk1("ifu_alone t2 rsp_valid", ifu_rsp_valid, 1'b0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #1;
    chk1 ("ifu_alone t3 rsp_valid", ifu_rsp_valid, 1'b1);
    chk32("ifu_alone t3 rsp_data", ifu_rsp_data, 32'h0000_0413);
    chk1 ("ifu_alone t3 rsp_err", ifu_rsp_err, 1'b0);
    chk1 ("ifu_alone t3 busy", busy, 1'b0);
    next_cycle();
    #1;
    chk1 ("ifu_alone t4 rsp_valid", ifu_rsp_valid, 1'b0);
    chk32("ifu_alone t4 data held", ifu_rsp_data, 32'h0000_0413);

    // ---------------- LSU store, ready delayed 5 cycles ----------------
    next_cycle();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'b0011;
    mem_req_ready = 1'b0;
    #1;
    chk1("store grant", lsu_req_ready, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      lsu_req_valid = 1'b0;
      lsu_addr      = 32'h0000_0000;
      lsu_wen       = 1'b0;
      lsu_wdata     = 32'h0;
      lsu_wmask     = 4'h0;
      mem_req_ready = (k == 6);
      #1;
      chk1 ($sformatf("store t%0d mem_req_valid", k), mem_req_valid, 1'b1);
      chk32($sformatf("store t%0d mem_addr", k), mem_addr, 32'h8000_1000);
      chk1 ($sformatf("store t%0d mem_wen", k), mem_wen, 1'b1);
      chk32($sformatf("store t%0d mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      chk32($sformatf("store t%0d mem_wmask", k), 32'(mem_wmask), 32'h3);
      chk1 ($sformatf("store t%0d owner", k), owner, 1'b1);
    end
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    #1;
    chk1("store t7 mem_req_valid", mem_req_valid, 1'b0);
    chk1("store t7 lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #1;
    chk1 ("store t8 lsu_rsp_valid", lsu_rsp_valid, 1'b1);
    chk1 ("store t8 lsu_rsp_err", lsu_rsp_err, 1'b0);
    chk32("store t8 lsu_rsp_data", lsu_rsp_data, 32'h5555_5555);
    chk1 ("store t8 ifu_rsp_valid", ifu_rsp_valid, 1'b0);

    // ---------------- timeout: back-end never responds ----------------
    next_cycle();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    mem_req_ready = 1'b1;
    #1;
    chk1("timeout grant", ifu_req_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      ifu_req_valid = 1'b0;
      #1;
      chk1($sformatf("timeout t%0d busy", k), busy, 1'b1);
      chk1($sformatf("timeout t%0d ifu_rsp_valid", k), ifu_rsp_valid, 1'b0);
      if (k == 1) begin
        chk1 ("timeout t1 mem_req_valid", mem_req_valid, 1'b1);
        chk1 ("timeout t1 mem_wen", mem_wen, 1'b0);
        chk32("timeout t1 mem_wmask", 32'(mem_wmask), 32'h0);
      end
      if (k == 2) chk1("timeout t2 mem_req_valid", mem_req_valid, 1'b0);
    end
    next_cycle();
    #1;
    chk1 ("timeout t9 ifu_rsp_valid", ifu_rsp_valid, 1'b1);
    chk1 ("timeout t9 ifu_rsp_err", ifu_rsp_err, 1'b1);
    chk32("timeout t9 ifu_rsp_data", ifu_rsp_data, 32'h0);
    chk1 ("timeout t9 busy", busy, 1'b0);
    next_cycle();
    #1;
    chk1("timeout t10 ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h9999_9999;
    #1;
    next_cycle();
    mem_rsp_valid = 1'b0;
    #1;
    chk1 ("late rsp ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    chk1 ("late rsp lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    chk32("late rsp ifu_rsp_data", ifu_rsp_data, 32'h0);
    chk1 ("late rsp busy", busy, 1'b0);

    // ---------------- reset during WAIT of an IFU fetch ----------------
    next_cycle();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0080;
    mem_req_ready = 1'b1;
    #1;
    chk1("rstwait grant", ifu_req_ready, 1'b1);
    next_cycle();
    ifu_req_valid = 1'b0;
    #1;
    next_cycle();
    #1;
    chk1("rstwait in wait busy", busy, 1'b1);
    sys_rst = 1'b1;
    #1;
    chk1 ("rstwait busy", busy, 1'b0);
    chk1 ("rstwait mem_req_valid", mem_req_valid, 1'b0);
    chk32("rstwait mem_addr", mem_addr, 32'h0);
    chk1 ("rstwait ifu_rsp_err", ifu_rsp_err, 1'b0);
    chk32("rstwait lsu_rsp_data", lsu_rsp_data, 32'h0);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h7777_7777;
    next_cycle();
    sys_rst       = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3000;
    lsu_wen       = 1'b0;
    #1;
    chk1("post-rst tie lsu_ready", lsu_req_ready, 1'b1);
    chk1("post-rst tie ifu_ready", ifu_req_ready, 1'b0);
    chk1("post-rst ifu_rsp_valid", ifu_rsp_valid, 1'b0);

    // ---------------- LSU load with back-end error, then clean load ----------------
    next_cycle();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk1 ("errload ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    chk1 ("errload mem_req_valid", mem_req_valid, 1'b1);
    chk32("errload mem_addr", mem_addr, 32'h8000_3000);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    mem_rsp_err   = 1'b1;
    #1;
    next_cycle();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3004;
    #1;
    chk1 ("errload lsu_rsp_valid", lsu_rsp_valid, 1'b1);
    chk1 ("errload lsu_rsp_err", lsu_rsp_err, 1'b1);
    chk32("errload lsu_rsp_data", lsu_rsp_data, 32'h1234_5678);
    chk1 ("errload regrant same cycle", lsu_req_ready, 1'b1);
    next_cycle();
    lsu_req_valid = 1'b0;
    #1;
    chk1 ("cleanload lsu_rsp_valid low", lsu_rsp_valid, 1'b0);
    chk1 ("cleanload err held", lsu_rsp_err, 1'b1);
    chk32("cleanload mem_addr", mem_addr, 32'h8000_3004);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_0001;
    #1;
    next_cycle();
    mem_rsp_valid = 1'b0;
    #1;
    chk1 ("cleanload lsu_rsp_valid", lsu_rsp_valid, 1'b1);
    chk1 ("cleanload lsu_rsp_err", lsu_rsp_err, 1'b0);
    chk32("cleanload lsu_rsp_data", lsu_rsp_data, 32'hCAFE_0001);
    chk1 ("cleanload ifu_rsp_valid", ifu_rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
